dmem_arbiter: RTL and testbench

//  Shares the single-port synchronous data RAM between the CPU data port and a host
//  (loader/debug) port. The CPU cannot stall, so it owns every cycle it accesses; host

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: data-path width defaults and the data-RAM arbiter state encoding.
package cpu_pkg;

  localparam int WIDTH       = 16;
  localparam int DADDR_WIDTH = 8;
  localparam int MAX_WAIT    = 15;
  localparam int WAIT_W      = 4;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_PEND  = 2'd1;
  localparam logic [1:0] ARB_RDATA = 2'd2;
  localparam logic [1:0] ARB_ACK   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ARB_IDLE,
    PEND  = ARB_PEND,
    RDATA = ARB_RDATA,
    ACK   = ARB_ACK
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port (never stalled) and a host
// port whose single held request is issued only in a CPU-idle cycle.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int width       = WIDTH,
  parameter int daddr_width = DADDR_WIDTH,
  parameter int MAX_WAIT    = cpu_pkg::MAX_WAIT,
  parameter int WAIT_W      = cpu_pkg::WAIT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_dact,
  input  logic [daddr_width-1:0] cpu_daddr,
  input  logic                   cpu_dwrite,
  input  logic [width-1:0]       cpu_dD,
  output logic [width-1:0]       cpu_dQ,
  input  logic                   host_req,
  output logic                   host_rdy,
  input  logic                   host_we,
  input  logic [daddr_width-1:0] host_addr,
  input  logic [width-1:0]       host_wdata,
  output logic                   host_ack,
  output logic [width-1:0]       host_rdata,
  output logic                   host_starve,
  input  logic                   starve_clr,
  output logic [daddr_width-1:0] ram_addr,
  output logic                   ram_we,
  output logic [width-1:0]       ram_wdata,
  input  logic [width-1:0]       ram_rdata,
  output logic [1:0]             state_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e             state_q, state_d;
  logic                   hold_we;
  logic [daddr_width-1:0] hold_addr;
  logic [width-1:0]       hold_wdata;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   accept, blocked, starve_set;

  // Host handshake: a request transfers on a rising edge where host_req && host_rdy;
  // host_rdy is high only in IDLE, and host_ack pulses once per accepted request.
  assign accept     = host_req && (state_q == IDLE);
  assign blocked    = (state_q == PEND) && cpu_dact;
  assign starve_set = blocked && (wait_cnt == (WAIT_MAX - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_req) state_d = PEND;
      PEND:    if (!cpu_dact) state_d = RDATA;
      RDATA:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (accept) begin
      hold_we    <= host_we;
      hold_addr  <= host_addr;
      hold_wdata <= host_wdata;
    end
  end

  // Wait counter saturates so that a clear during a long stall is not undone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           wait_cnt <= '0;
    else if (accept)                        wait_cnt <= '0;
    else if (blocked && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        host_starve <= 1'b0;
    else if (starve_set) host_starve <= 1'b1;
    else if (starve_clr) host_starve <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             host_rdata <= '0;
    else if (state_q == RDATA && !hold_we)    host_rdata <= ram_rdata;
  end

  always_comb begin
    ram_addr  = cpu_daddr;
    ram_wdata = cpu_dD;
    ram_we    = 1'b0;
    if (cpu_dact) begin
      ram_we = cpu_dwrite;
    end else if (state_q == PEND) begin
      ram_addr  = hold_addr;
      ram_wdata = hold_wdata;
      ram_we    = hold_we;
    end
  end

  assign cpu_dQ    = ram_rdata;
  assign host_rdy  = (state_q == IDLE);
  assign host_ack  = (state_q == ACK);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural sync RAM, table-driven mux vectors, then directed
// host write/read, starvation, back-to-back and reset sequences.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  localparam int W  = WIDTH;
  localparam int AW = DADDR_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_dact, cpu_dwrite;
  logic [AW-1:0] cpu_daddr;
  logic [W-1:0]  cpu_dD, cpu_dQ;
  logic          host_req, host_rdy, host_we, host_ack, host_starve, starve_clr;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata, host_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata, ram_rdata;
  logic [1:0]    state_dbg;

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [W-1:0]  exp_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            ack_cnt;

  typedef struct {
    logic          act;
    logic [AW-1:0] addr;
    logic          we;
    logic [W-1:0]  d;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [W-1:0]  e_wd;
  } vec_t;
  vec_t vecs[6];

  dmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_dact(cpu_dact), .cpu_daddr(cpu_daddr), .cpu_dwrite(cpu_dwrite),
    .cpu_dD(cpu_dD), .cpu_dQ(cpu_dQ),
    .host_req(host_req), .host_rdy(host_rdy), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_starve(host_starve), .starve_clr(starve_clr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  // Single-port sync RAM, read data one cycle after address; reloaded while in reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(AW'(i));
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " host_rdy"},    32'(host_rdy), 32'd1);
    check({tag, " host_ack"},    32'(host_ack), 32'd0);
    check({tag, " host_rdata"},  32'(host_rdata), 32'd0);
    check({tag, " host_starve"}, 32'(host_starve), 32'd0);
    check({tag, " state"},       32'(state_dbg), 32'(ARB_IDLE));
  endtask

  // Waits (bounded) for host_ack at the sampling point; reads are scored against exp_q.
  task automatic wait_ack(input string name, input bit is_read);
    bit seen = 1'b0;
    int k = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      if (host_ack) seen = 1'b1;
      else step();
      k++;
    end
    check({name, " ack seen"}, 32'(seen), 32'd1);
    if (seen && is_read && exp_q.size() > 0)
      check({name, " rdata"}, 32'(host_rdata), 32'(exp_q.pop_front()));
    step();
  endtask

  task automatic post_reset_idle(input string tag);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check({tag, " no ack after release"}, 32'(host_ack), 32'd0);
      check({tag, " rdy after release"},    32'(host_rdy), 32'd1);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cpu_dact = 1'b0; cpu_daddr = '0; cpu_dwrite = 1'b0; cpu_dD = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; starve_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    step();
    reset_n = 1'b1;

    // RAM mux with no host request pending.
    vecs[0] = '{1'b1, 8'h80, 1'b1, 16'hBEEF, 8'h80, 1'b1, 16'hBEEF};
    vecs[1] = '{1'b1, 8'h81, 1'b0, 16'h1234, 8'h81, 1'b0, 16'h1234};
    vecs[2] = '{1'b0, 8'h82, 1'b1, 16'h5555, 8'h82, 1'b0, 16'h5555};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 16'h0000, 8'hFF, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 8'h00, 1'b1, 16'hFFFF, 8'h00, 1'b1, 16'hFFFF};
    vecs[5] = '{1'b1, 8'h80, 1'b0, 16'h0000, 8'h80, 1'b0, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      cpu_dact = vecs[i].act; cpu_daddr = vecs[i].addr;
      cpu_dwrite = vecs[i].we; cpu_dD = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d ram_addr", i),  32'(ram_addr),  32'(vecs[i].e_addr));
      check($sformatf("vec%0d ram_we", i),    32'(ram_we),    32'(vecs[i].e_we));
      check($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wd));
      step();
    end
    cpu_dact = 1'b0; cpu_dwrite = 1'b0; cpu_dD = '0;
    @(negedge clk);
    check("cpu read-back 0x80", 32'(cpu_dQ), 32'h0000BEEF);
    step();

    // Host write 0x12 -> 0x05 with the CPU idle.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 16'h0012;
    @(negedge clk);
    check("wr rdy before accept", 32'(host_rdy), 32'd1);
    step();
    host_req = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("wr issue ram_we",    32'(ram_we),    32'd1);
        check("wr issue ram_addr",  32'(ram_addr),  32'h05);
        check("wr issue ram_wdata", 32'(ram_wdata), 32'h0012);
      end
      check($sformatf("wr ack cycle %0d", n), 32'(host_ack), 32'(n == 3));
      check($sformatf("wr rdy cycle %0d", n), 32'(host_rdy), 32'(n == 4));
      step();
    end
    cpu_dact = 1'b1; cpu_daddr = 8'h05; cpu_dwrite = 1'b0;
    step();
    cpu_dact = 1'b0;
    @(negedge clk);
    check("cpu sees host write", 32'(cpu_dQ), 32'h0012);
    step();

    // Host read 0x20 blocked by the CPU for 4 cycles.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    exp_q.push_back(init_val(8'h20));
    step();
    host_req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      cpu_dact = (n <= 4); cpu_daddr = 8'(8'h40 + n);
      @(negedge clk);
      if (n <= 4) begin
        check($sformatf("rd blocked addr %0d", n), 32'(ram_addr), 32'(8'h40 + n));
        check($sformatf("rd blocked we %0d", n),   32'(ram_we), 32'd0);
      end
      if (n == 5) check("rd issue addr", 32'(ram_addr), 32'h20);
      check($sformatf("rd ack cycle %0d", n), 32'(host_ack), 32'(n == 7));
      if (host_ack && exp_q.size() > 0)
        check("rd rdata 0x20", 32'(host_rdata), 32'(exp_q.pop_front()));
      step();
    end
    cpu_dact = 1'b0;

    // Starvation: 20+ blocked cycles, clear while saturated.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    exp_q.push_back(init_val(8'h30));
    step();
    host_req = 1'b0; cpu_dact = 1'b1; cpu_daddr = 8'h90;
    for (int n = 1; n <= 22; n++) begin
      starve_clr = (n == 21);
      @(negedge clk);
      check($sformatf("starve cycle %0d", n), 32'(host_starve), 32'(n >= 16 && n <= 21));
      check($sformatf("starve no ack %0d", n), 32'(host_ack), 32'd0);
      step();
    end
    starve_clr = 1'b0; cpu_dact = 1'b0;
    wait_ack("starve read", 1'b1);

    // Clear and set on the same edge: set wins.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h31; host_wdata = 16'h7777;
    step();
    host_req = 1'b0; cpu_dact = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      starve_clr = (n == 15);
      @(negedge clk);
      check($sformatf("set-vs-clr cycle %0d", n), 32'(host_starve), 32'(n == 16));
      step();
    end
    starve_clr = 1'b1; cpu_dact = 1'b0;
    step();
    starve_clr = 1'b0;
    @(negedge clk);
    check("starve cleared", 32'(host_starve), 32'd0);
    wait_ack("set-vs-clr write", 1'b0);

    // host_req held high: one accept per IDLE, one ack per accept.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21; cpu_dact = 1'b0;
    ack_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check($sformatf("held rdy %0d", n), 32'(host_rdy), 32'((n % 4) == 0));
      check($sformatf("held ack %0d", n), 32'(host_ack), 32'((n % 4) == 3));
      if ((n % 4) == 0) exp_q.push_back(init_val(8'h21));
      if (host_ack) begin
        ack_cnt++;
        if (exp_q.size() > 0) check("held rdata", 32'(host_rdata), 32'(exp_q.pop_front()));
      end
      step();
    end
    host_req = 1'b0;
    check("held ack count", 32'(ack_cnt), 32'd3);

    // Reset during RDATA (host_rdata currently nonzero).
    host_req = 1'b1; host_addr = 8'h22;
    step();
    host_req = 1'b0;
    step();
    @(negedge clk);
    check("pre-reset state RDATA", 32'(state_dbg), 32'(ARB_RDATA));
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset in RDATA");
    step();
    reset_n = 1'b1;
    post_reset_idle("RDATA reset");

    // Reset during PEND.
    host_req = 1'b1; host_addr = 8'h23;
    step();
    host_req = 1'b0; cpu_dact = 1'b1;
    step();
    @(negedge clk);
    check("pre-reset state PEND", 32'(state_dbg), 32'(ARB_PEND));
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset in PEND");
    step();
    reset_n = 1'b1; cpu_dact = 1'b0;
    post_reset_idle("PEND reset");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
